counter_control_fsm: RTL and testbench
======================================

# counter_control_fsm

Front-end controller for the 4-bit feature counter. It debounces the raw clear, load and pause buttons and synchronises the direction and speed switches. It then drives the counter's active-low reset/load, upDown, clkSel and loadData inputs so that each command is consumed exactly once, on a divided-clock sample. It sits between the board I/O and the counter, and implements pause by having the counter reload its own frozen value on every sample.

## Interface
- DB_CYCLES, 16: consecutive stable synchronised samples required to accept a button level change; counter width is clog2(DB_CYCLES+1).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- clrBtn  in  1  raw clear button, active-low (pressed = 0).
- loadBtn  in  1  raw load button, active-low.
- pauseBtn  in  1  raw pause-toggle button, active-low.
- upDownSw  in  1  direction switch; 0 = up, 1 = down.
- speedSw  in  2  divider select for the counter.
- loadData  in  4  value to load.
- tick  in  1  one-clk strobe, high in the clk cycle whose control values the counter samples.
- countIn  in  4  current counter value.
- cntReset  out  1  counter reset, active-low.
- cntLoad  out  1  counter load, active-low.
- cntUpDown  out  1  direction to counter.
- cntClkSel  out  2  divider select to counter.
- cntData  out  4  load data to counter.
- busy  out  1  high in CLR, LOAD, PCLR, PLOAD.
- paused  out  1  high in PAUSE, PCLR, PLOAD.
- state  out  3  current FSM state.

## Operation
- Reset values (asynchronous, applied mid-command too; any command in flight is aborted):
  - cntReset=1, cntLoad=1, cntUpDown=0, cntClkSel=00, cntData=0.
  - busy=0, paused=0, state=RUN.
  - Debounced levels = released (1); debounce counters = 0.
- Buttons: 2-flop synchroniser, then debouncer.
  - The debounced level flips after DB_CYCLES consecutive synced samples that differ from it. Any bounce resets the count.
  - A press event is a 1-cycle pulse on a debounced 1->0 transition. Release produces no event.
- Switches: 2-flop synchronised, no debounce.
  - cntUpDown and cntClkSel are loaded from the synced switches only at the clk edge ending a tick=1 cycle, in every state.
- State encoding: RUN=0, CLR=1, LOAD=2, PAUSE=3, PCLR=4, PLOAD=5; 6 and 7 go to RUN.
- Event priority in the same cycle: clear > load > pause. Losing events are dropped, not queued. Events arriving in CLR, LOAD, PCLR or PLOAD are dropped.
- RUN: cntReset=1, cntLoad=1; the counter free-runs.
  - clear event -> CLR.
  - load event -> LOAD with cntData<=loadData.
  - pause event -> PAUSE with cntData<=countIn (freeze value F).
- CLR/PCLR: cntReset=0, cntLoad=1.
  - The counter clears to 0 if cntUpDown=0, or to 15 if cntUpDown=1.
  - CLR exits to RUN at the edge ending the first tick=1 cycle spent in the state.
  - PCLR exits to PAUSE, with cntData set to the clear target (0 or 15, from the cntUpDown value sampled in that tick).
- LOAD/PLOAD: cntLoad=0, cntReset=1, cntData held.
  - LOAD exits to RUN at the edge ending the first tick=1 cycle spent in the state.
  - PLOAD exits to PAUSE; cntData stays at the loaded value.
- PAUSE: cntLoad=0 continuously with cntData=F, so the counter reloads F on every tick.
  - clear event -> PCLR.
  - load event -> PLOAD with cntData<=loadData.
  - pause event -> RUN (cntLoad=1 from the next cycle).
- If a tick coincides with PAUSE entry, the counter may advance once; it returns to F on the next tick.

## Timing
- All outputs are registered; no combinational path from input to output.
- Button latency: the state changes at the edge DB_CYCLES+3 edges after the first edge that samples a stable new raw level.
- A command is held from its entry edge through the first tick=1 cycle seen in the state, and is therefore consumed exactly once.
  - Minimum hold is 1 clk cycle (tick in the first cycle after entry).
  - Maximum hold is one full tick period.
- Switch changes reach the outputs within one tick period plus 2 clk cycles, and never change within a tick period, so clkSel is glitch-free between samples.

## Test plan
Bench settings: DB_CYCLES=4; tick every 8 clk cycles.
- Reset, then release with no buttons pressed -> all outputs at reset values; state=0 for 100 cycles; cntReset=cntLoad=1 throughout.
- loadBtn low with 2 cycles of bounce, then stable; loadData=4'hB -> exactly one LOAD; cntLoad=0 through exactly one tick; cntData=B; then state=RUN.
- upDownSw=1, then clrBtn -> cntReset=0 for one tick; cntUpDown=1 during that tick; state returns to 0.
- countIn=7, pauseBtn press -> state=3, cntLoad=0, cntData=7 across 5 ticks. Then load with loadData=2 -> PLOAD, then PAUSE with cntData=2. Pause again -> RUN, cntLoad=1.
- clrBtn and loadBtn pressed in the same cycle -> only CLR is entered; no LOAD follows. A press during CLR is ignored.
- Assert reset while in LOAD, mid-period -> cntLoad=1 and state=0 immediately, before the next clk edge.
- Toggle speedSw 00->10 mid-period -> cntClkSel changes only at the edge ending the next tick cycle.

Source files
------------

// File: rtl/counter_control_fsm.sv
// Front-end controller for the 4-bit feature counter: debounces the clear/load/pause
// buttons, synchronises the switches and sequences the counter's reset/load controls.
module counter_control_fsm #(
  parameter int DB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clrBtn,
  input  logic       loadBtn,
  input  logic       pauseBtn,
  input  logic       upDownSw,
  input  logic [1:0] speedSw,
  input  logic [3:0] loadData,
  input  logic       tick,
  input  logic [3:0] countIn,
  output logic       cntReset,
  output logic       cntLoad,
  output logic       cntUpDown,
  output logic [1:0] cntClkSel,
  output logic [3:0] cntData,
  output logic       busy,
  output logic       paused,
  output logic [2:0] state
);

  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    CLR   = 3'd1,
    LOAD  = 3'd2,
    PAUSE = 3'd3,
    PCLR  = 3'd4,
    PLOAD = 3'd5
  } stateT;

  logic [2:0] btnRaw;
  logic [2:0] btnPress;

  assign btnRaw = {pauseBtn, loadBtn, clrBtn};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gBtn
      logic          metaReg;
      logic          syncReg;
      logic          levelReg;
      logic          levelDlyReg;
      logic          pressReg;
      logic [CW-1:0] dbCountReg;

      // The press pulse comes from the delayed level so it lands one edge after the flip.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          metaReg     <= 1'b1;
          syncReg     <= 1'b1;
          levelReg    <= 1'b1;
          levelDlyReg <= 1'b1;
          pressReg    <= 1'b0;
          dbCountReg  <= '0;
        end else begin
          metaReg <= btnRaw[gi];
          syncReg <= metaReg;
          if (syncReg == levelReg) begin
            dbCountReg <= '0;
          end else if (dbCountReg == DB_LAST) begin
            levelReg   <= syncReg;
            dbCountReg <= '0;
          end else begin
            dbCountReg <= dbCountReg + 1'b1;
          end
          levelDlyReg <= levelReg;
          pressReg    <= levelDlyReg & ~levelReg;
        end
      end

      assign btnPress[gi] = pressReg;
    end
  endgenerate

  logic       clrEv;
  logic       loadEv;
  logic       pauseEv;

  assign clrEv   = btnPress[0];
  assign loadEv  = btnPress[1];
  assign pauseEv = btnPress[2];

  logic       upDownMetaReg;
  logic       upDownSyncReg;
  logic [1:0] speedMetaReg;
  logic [1:0] speedSyncReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upDownMetaReg <= 1'b0;
      upDownSyncReg <= 1'b0;
      speedMetaReg  <= 2'b00;
      speedSyncReg  <= 2'b00;
    end else begin
      upDownMetaReg <= upDownSw;
      upDownSyncReg <= upDownMetaReg;
      speedMetaReg  <= speedSw;
      speedSyncReg  <= speedMetaReg;
    end
  end

  stateT      stateReg;
  logic       cntResetReg;
  logic       cntLoadReg;
  logic       cntUpDownReg;
  logic [1:0] cntClkSelReg;
  logic [3:0] cntDataReg;
  logic       busyReg;
  logic       pausedReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= RUN;
      cntResetReg  <= 1'b1;
      cntLoadReg   <= 1'b1;
      cntUpDownReg <= 1'b0;
      cntClkSelReg <= 2'b00;
      cntDataReg   <= 4'h0;
      busyReg      <= 1'b0;
      pausedReg    <= 1'b0;
    end else begin
      // Switch values only move at a sample edge, so clkSel never changes between samples.
      if (tick) begin
        cntUpDownReg <= upDownSyncReg;
        cntClkSelReg <= speedSyncReg;
      end

      case (stateReg)
        RUN: begin
          cntResetReg <= 1'b1;
          cntLoadReg  <= 1'b1;
          busyReg     <= 1'b0;
          pausedReg   <= 1'b0;
          if (clrEv) begin
            stateReg    <= CLR;
            cntResetReg <= 1'b0;
            busyReg     <= 1'b1;
          end else if (loadEv) begin
            stateReg   <= LOAD;
            cntLoadReg <= 1'b0;
            cntDataReg <= loadData;
            busyReg    <= 1'b1;
          end else if (pauseEv) begin
            stateReg   <= PAUSE;
            cntLoadReg <= 1'b0;
            cntDataReg <= countIn;
            pausedReg  <= 1'b1;
          end
        end

        CLR: begin
          if (tick) begin
            stateReg    <= RUN;
            cntResetReg <= 1'b1;
            busyReg     <= 1'b0;
          end
        end

        LOAD: begin
          if (tick) begin
            stateReg   <= RUN;
            cntLoadReg <= 1'b1;
            busyReg    <= 1'b0;
          end
        end

        PAUSE: begin
          cntResetReg <= 1'b1;
          cntLoadReg  <= 1'b0;
          if (clrEv) begin
            stateReg    <= PCLR;
            cntResetReg <= 1'b0;
            cntLoadReg  <= 1'b1;
            busyReg     <= 1'b1;
          end else if (loadEv) begin
            stateReg   <= PLOAD;
            cntDataReg <= loadData;
            busyReg    <= 1'b1;
          end else if (pauseEv) begin
            stateReg   <= RUN;
            cntLoadReg <= 1'b1;
            pausedReg  <= 1'b0;
          end
        end

        PCLR: begin
          // The freeze value becomes whatever the clear produced in this sample.
          if (tick) begin
            stateReg    <= PAUSE;
            cntResetReg <= 1'b1;
            cntLoadReg  <= 1'b0;
            cntDataReg  <= {4{cntUpDownReg}};
            busyReg     <= 1'b0;
          end
        end

        PLOAD: begin
          if (tick) begin
            stateReg <= PAUSE;
            busyReg  <= 1'b0;
          end
        end

        default: begin
          stateReg    <= RUN;
          cntResetReg <= 1'b1;
          cntLoadReg  <= 1'b1;
          busyReg     <= 1'b0;
          pausedReg   <= 1'b0;
        end
      endcase
    end
  end

  assign cntReset  = cntResetReg;
  assign cntLoad   = cntLoadReg;
  assign cntUpDown = cntUpDownReg;
  assign cntClkSel = cntClkSelReg;
  assign cntData   = cntDataReg;
  assign busy      = busyReg;
  assign paused    = pausedReg;
  assign state     = stateReg;

endmodule

// File: tb/tb_counter_control_fsm.sv
// Directed bench for counter_control_fsm with DB_CYCLES=4 and a tick every 8 clk cycles.
module tb_counter_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       clrBtn;
  logic       loadBtn;
  logic       pauseBtn;
  logic       upDownSw;
  logic [1:0] speedSw;
  logic [3:0] loadData;
  logic       tick;
  logic [3:0] countIn;
  logic       cntReset;
  logic       cntLoad;
  logic       cntUpDown;
  logic [1:0] cntClkSel;
  logic [3:0] cntData;
  logic       busy;
  logic       paused;
  logic [2:0] state;

  counter_control_fsm #(.DB_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .clrBtn   (clrBtn),
    .loadBtn  (loadBtn),
    .pauseBtn (pauseBtn),
    .upDownSw (upDownSw),
    .speedSw  (speedSw),
    .loadData (loadData),
    .tick     (tick),
    .countIn  (countIn),
    .cntReset (cntReset),
    .cntLoad  (cntLoad),
    .cntUpDown(cntUpDown),
    .cntClkSel(cntClkSel),
    .cntData  (cntData),
    .busy     (busy),
    .paused   (paused),
    .state    (state)
  );

  always #5 clk = ~clk;

  // Tick is high for one full cycle out of every eight.
  initial begin
    int tc;
    tc   = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tc   = (tc + 1) % 8;
      tick = (tc == 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  int         checks = 0;
  int         failures = 0;
  int         entryCnt [8];
  int         tickLoadLow;
  int         tickResetLow;
  int         lowCycles;
  logic [3:0] lastLoadData;
  logic       lastClrUpDown;
  logic [2:0] prevState;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic clearStats();
    foreach (entryCnt[i]) entryCnt[i] = 0;
    tickLoadLow   = 0;
    tickResetLow  = 0;
    lowCycles     = 0;
    lastLoadData  = 4'h0;
    lastClrUpDown = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    if (state !== prevState) entryCnt[state]++;
    prevState = state;
    if (tick && !cntLoad) begin
      tickLoadLow++;
      lastLoadData = cntData;
    end
    if (tick && !cntReset) begin
      tickResetLow++;
      lastClrUpDown = cntUpDown;
    end
    if (!cntLoad) lowCycles++;
  endtask

  task automatic waitState(input logic [2:0] target, input int budget, input string tag);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      step();
      n++;
    end
    checkVal(tag, 32'(state), 32'(target));
  endtask

  initial begin
    int   bad;
    int   ticks;
    int   lat;
    logic found;

    reset    = 1'b0;
    clrBtn   = 1'b1;
    loadBtn  = 1'b1;
    pauseBtn = 1'b1;
    upDownSw = 1'b0;
    speedSw  = 2'b00;
    loadData = 4'h0;
    countIn  = 4'h0;
    prevState = 3'd0;
    clearStats();

    repeat (3) @(negedge clk);
    checkVal("rst_cntReset", 32'(cntReset), 32'd1);
    checkVal("rst_cntLoad", 32'(cntLoad), 32'd1);
    checkVal("rst_cntUpDown", 32'(cntUpDown), 32'd0);
    checkVal("rst_cntClkSel", 32'(cntClkSel), 32'd0);
    checkVal("rst_cntData", 32'(cntData), 32'd0);
    checkVal("rst_busy", 32'(busy), 32'd0);
    checkVal("rst_paused", 32'(paused), 32'd0);
    checkVal("rst_state", 32'(state), 32'd0);
    reset = 1'b1;

    // Idle: nothing pressed for 100 cycles.
    bad = 0;
    repeat (100) begin
      step();
      if (state !== 3'd0 || cntReset !== 1'b1 || cntLoad !== 1'b1) bad++;
    end
    checkVal("idle_violations", 32'(bad), 32'd0);

    // Bouncy load press.
    clearStats();
    loadData = 4'hB;
    loadBtn = 1'b0; step();
    loadBtn = 1'b1; step();
    loadBtn = 1'b0;
    repeat (40) step();
    checkVal("load_entries", 32'(entryCnt[2]), 32'd1);
    checkVal("load_ticks", 32'(tickLoadLow), 32'd1);
    checkVal("load_data", 32'(lastLoadData), 32'hB);
    checkVal("load_hold_in_range", 32'(lowCycles >= 1 && lowCycles <= 8), 32'd1);
    checkVal("load_done_state", 32'(state), 32'd0);
    loadBtn = 1'b1;
    repeat (12) step();

    // Clear while counting down; exact button latency is DB_CYCLES+3 edges.
    upDownSw = 1'b1;
    repeat (12) step();
    checkVal("updown_synced", 32'(cntUpDown), 32'd1);
    clearStats();
    clrBtn = 1'b0;
    lat = 0;
    while (state !== 3'd1 && lat < 20) begin
      step();
      lat++;
    end
    checkVal("clr_latency", 32'(lat), 32'd8);
    repeat (20) step();
    checkVal("clr_ticks", 32'(tickResetLow), 32'd1);
    checkVal("clr_updown", 32'(lastClrUpDown), 32'd1);
    checkVal("clr_done_state", 32'(state), 32'd0);
    clrBtn = 1'b1;
    repeat (12) step();

    // Pause freezes countIn=7 even after countIn moves on.
    countIn = 4'h7;
    pauseBtn = 1'b0;
    waitState(3'd3, 20, "pause_enter");
    pauseBtn = 1'b1;
    countIn = 4'h9;
    bad = 0;
    ticks = 0;
    repeat (40) begin
      step();
      if (state !== 3'd3 || cntLoad !== 1'b0 || cntData !== 4'h7) bad++;
      if (tick) ticks++;
    end
    checkVal("pause_hold_violations", 32'(bad), 32'd0);
    checkVal("pause_ticks", 32'(ticks), 32'd5);
    checkVal("pause_paused", 32'(paused), 32'd1);

    // Load while paused.
    loadData = 4'h2;
    loadBtn = 1'b0;
    waitState(3'd5, 20, "pload_enter");
    checkVal("pload_busy", 32'(busy), 32'd1);
    checkVal("pload_paused", 32'(paused), 32'd1);
    checkVal("pload_cntLoad", 32'(cntLoad), 32'd0);
    loadBtn = 1'b1;
    waitState(3'd3, 12, "pload_exit");
    checkVal("pload_exit_data", 32'(cntData), 32'h2);
    checkVal("pload_exit_busy", 32'(busy), 32'd0);
    repeat (12) step();

    // Clear while paused with cntUpDown=1: new freeze value is 15.
    clrBtn = 1'b0;
    waitState(3'd4, 20, "pclr_enter");
    checkVal("pclr_cntReset", 32'(cntReset), 32'd0);
    checkVal("pclr_cntLoad", 32'(cntLoad), 32'd1);
    clrBtn = 1'b1;
    waitState(3'd3, 12, "pclr_exit");
    checkVal("pclr_exit_data", 32'(cntData), 32'hF);
    checkVal("pclr_exit_cntLoad", 32'(cntLoad), 32'd0);
    checkVal("pclr_exit_cntReset", 32'(cntReset), 32'd1);
    repeat (12) step();

    pauseBtn = 1'b0;
    waitState(3'd0, 20, "resume_run");
    checkVal("resume_cntLoad", 32'(cntLoad), 32'd1);
    checkVal("resume_paused", 32'(paused), 32'd0);
    pauseBtn = 1'b1;
    repeat (12) step();

    // Clear and load together, then a pause press landing inside CLR.
    clearStats();
    clrBtn = 1'b0;
    loadBtn = 1'b0;
    step();
    pauseBtn = 1'b0;
    repeat (30) step();
    checkVal("prio_clr_entries", 32'(entryCnt[1]), 32'd1);
    checkVal("prio_load_entries", 32'(entryCnt[2]), 32'd0);
    checkVal("prio_pause_entries", 32'(entryCnt[3]), 32'd0);
    checkVal("prio_final_state", 32'(state), 32'd0);
    clrBtn = 1'b1;
    loadBtn = 1'b1;
    pauseBtn = 1'b1;
    repeat (12) step();

    // Asynchronous reset in the middle of LOAD.
    loadData = 4'h5;
    loadBtn = 1'b0;
    waitState(3'd2, 20, "rst_load_enter");
    loadBtn = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkVal("async_rst_cntLoad", 32'(cntLoad), 32'd1);
    checkVal("async_rst_state", 32'(state), 32'd0);
    checkVal("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prevState = state;
    repeat (12) step();
    checkVal("post_rst_state", 32'(state), 32'd0);
    checkVal("post_rst_cntLoad", 32'(cntLoad), 32'd1);

    // speedSw change mid-period reaches cntClkSel only at the next sample edge.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (tick) found = 1'b1;
    end
    checkVal("tick_phase_found", 32'(found), 32'd1);
    repeat (3) step();
    speedSw = 2'b10;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      step();
      if (tick) found = 1'b1;
    end
    checkVal("clksel_tick_found", 32'(found), 32'd1);
    checkVal("clksel_before_edge", 32'(cntClkSel), 32'd0);
    step();
    checkVal("clksel_after_edge", 32'(cntClkSel), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
